instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Parametrised successor to the fixed 16-entry combinational instruction store.
- Adds a writable program memory (loader port), an internal program counter, a run/halt state machine, registered fetch with stall backpressure, jumps, a HALT opcode and configurable end-of-memory wrap.
- Sits between the program loader/testbench and the decode/accumulator datapath.

Parameters:
- DATA_W, 16: instruction width; opcode is the top OPCODE_W bits.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W words.
- OPCODE_W, 4: opcode field width.
- HALT_OP, 4'b1111: opcode value that stops fetching.
- WRAP, 0: at the last address, 1 = wrap pc to 0, 0 = halt.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_en  in  1  write load_data to memory at load_addr.
- load_addr  in  ADDR_W  loader write address.
- load_data  in  DATA_W  loader write data.
- start  in  1  begin execution at address 0.
- stall  in  1  consumer backpressure; freeze fetch.
- jump_en  in  1  redirect pc.
- jump_addr  in  ADDR_W  jump target.
- instr  out  DATA_W  fetched instruction (registered).
- instr_valid  out  1  instr holds a new, executable word.
- pc  out  ADDR_W  address of the next word to fetch.
- running  out  1  FSM is in FETCH.
- done  out  1  sticky; set on halt or end of memory, cleared by start.

Behaviour:
- Reset (async, rst_n=0): state IDLE; pc=0, instr=0, instr_valid=0, running=0, done=0. Memory contents are not reset.
- A reset asserted mid-run aborts immediately. The program stays in memory and needs a new start.
- States: IDLE, FETCH, HALT.
- Loading:
  - load_en is honoured only in IDLE or HALT; mem[load_addr] <= load_data at the edge.
  - load_en in FETCH is ignored; memory is unchanged.
- start in IDLE or HALT:
  - Next state FETCH; pc <= 0, done <= 0, instr_valid <= 0, running <= 1.
  - start during FETCH is ignored.
  - If load_en and start arrive in the same cycle, the write completes. A write to address 0 is visible to the first fetch.
- FETCH edge, precedence jump > stall > fetch:
  - jump_en: pc <= jump_addr, instr_valid <= 0 (one bubble), instr held.
  - stall (no jump): pc, instr and instr_valid all held.
  - fetch: w = mem[pc]; instr <= w.
    - If w opcode == HALT_OP: instr_valid <= 0, state HALT, running <= 0, done <= 1. The halt word is never flagged valid.
    - Else if pc == DEPTH-1 and WRAP=0: instr_valid <= 1, state HALT, running <= 0, done <= 1. The final word is still valid for that cycle.
    - Else if pc == DEPTH-1 and WRAP=1: instr_valid <= 1, pc <= 0.
    - Else: instr_valid <= 1, pc <= pc+1 (modulo 2**ADDR_W).
- Latency:
  - start edge N leaves running=1, pc=0.
  - Edge N+1 gives instr=mem[0], instr_valid=1, pc=1.
  - Steady state: one word per unstalled cycle.
- In HALT: instr_valid <= 0 on entry and stays 0. instr keeps its last value. pc is frozen.
- jump_en and stall outside FETCH are ignored.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/FETCH/HALT);
  - opcode constants (ADD=0000, MUL=0100, DIV=0101, OUT=0110, HALT=1111);
  - an opcode field-extract helper.
- One sub-module: instr_mem, a DEPTH x DATA_W RAM with a synchronous write port and an asynchronous read port. The FSM/pc logic stays in instr_fetch_unit.

Test Plan:
- Load 0x0100, 0x4100, 0x5060, 0xF000 at addresses 0..3; start -> valid words 0x0100, 0x4100, 0x5060 on three consecutive cycles; then instr_valid=0, done=1, running=0, pc=3.
- Same program with stall high for 2 cycles after the first valid word -> instr stays 0x0100 with valid=1 for 3 cycles; the sequence then resumes unchanged.
- Load a program with no HALT, WRAP=0 -> 16 valid words (addresses 0..15); done=1 after address 15. With WRAP=1 -> address 0 follows address 15 and done stays 0.
- jump_en=1, jump_addr=6 while pc=2, with stall also high -> one bubble (valid=0); the next valid word is mem[6]; pc=7.
- load_en in FETCH writing 0xAAAA to address 5 -> mem[5] unchanged on the later fetch. After HALT, reload address 0 and start -> the new word appears first and done clears.
- Assert rst_n=0 mid-run at pc=4 -> outputs go to 0 asynchronously (before the next edge); start after release re-executes from address 0 with the memory intact.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared state encoding, opcode constants and opcode extract helper
package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam logic [3:0] OPC_ADD  = 4'b0000;
   localparam logic [3:0] OPC_MUL  = 4'b0100;
   localparam logic [3:0] OPC_DIV  = 4'b0101;
   localparam logic [3:0] OPC_OUT  = 4'b0110;
   localparam logic [3:0] OPC_HALT = 4'b1111;

   localparam int WORD_MAX = 64;

   // Returns the top opcode_w bits of a data_w-wide word, zero-extended.
   function automatic logic [WORD_MAX-1:0] opcode_field(input logic [WORD_MAX-1:0] word,
                                                        input int data_w,
                                                        input int opcode_w);
      logic [WORD_MAX-1:0] mask;
      mask = (WORD_MAX'(1) << opcode_w) - WORD_MAX'(1);
      return (word >> (data_w - opcode_w)) & mask;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_mem.sv
// rtl/instr_fetch_unit_mem.sv - program RAM, synchronous write, asynchronous read
module instr_mem #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents survive reset so a program can be re-run after an abort.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - run/halt fetch engine with pc, jumps, stall and loader port
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int                    DATA_W   = 16,
   parameter int                    ADDR_W   = 4,
   parameter int                    OPCODE_W = 4,
   parameter logic [OPCODE_W-1:0]   HALT_OP  = 4'b1111,
   parameter bit                    WRAP     = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              start,
   input  logic              stall,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              running,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t              state;
   logic [DATA_W-1:0]   rd_data;
   logic [OPCODE_W-1:0] rd_op;
   logic                mem_we;

   // The loader owns the memory only while no program is executing.
   assign mem_we = load_en && (state != ST_FETCH);
   assign rd_op  = OPCODE_W'(opcode_field(WORD_MAX'(rd_data), DATA_W, OPCODE_W));

   instr_mem #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_mem (
      .clk  (clk),
      .we   (mem_we),
      .waddr(load_addr),
      .wdata(load_data),
      .raddr(pc),
      .rdata(rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         pc          <= '0;
         instr       <= '0;
         instr_valid <= 1'b0;
         running     <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_HALT: begin
               instr_valid <= 1'b0;
               if (start) begin
                  state   <= ST_FETCH;
                  pc      <= '0;
                  done    <= 1'b0;
                  running <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (jump_en) begin
                  pc          <= jump_addr;
                  instr_valid <= 1'b0;
               end else if (!stall) begin
                  instr <= rd_data;
                  if (rd_op == HALT_OP) begin
                     instr_valid <= 1'b0;
                     state       <= ST_HALT;
                     running     <= 1'b0;
                     done        <= 1'b1;
                  end else if (pc == LAST_ADDR && !WRAP) begin
                     instr_valid <= 1'b1;
                     state       <= ST_HALT;
                     running     <= 1'b0;
                     done        <= 1'b1;
                  end else begin
                     // Increment wraps naturally to 0 at the last address.
                     instr_valid <= 1'b1;
                     pc          <= pc + ADDR_W'(1);
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        load_en;
   logic [3:0]  load_addr;
   logic [15:0] load_data;
   logic        start;
   logic        stall;
   logic        jump_en;
   logic [3:0]  jump_addr;

   logic [15:0] instr;
   logic        instr_valid;
   logic [3:0]  pc;
   logic        running;
   logic        done;

   logic [15:0] w_instr;
   logic        w_instr_valid;
   logic [3:0]  w_pc;
   logic        w_running;
   logic        w_done;

   int n_checks;
   int n_fail;

   logic [15:0] prog_a [0:3];
   logic [15:0] prog_b [0:7];

   instr_fetch_unit #(
      .DATA_W(16), .ADDR_W(4), .OPCODE_W(4), .HALT_OP(4'b1111), .WRAP(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .start(start), .stall(stall), .jump_en(jump_en),
      .jump_addr(jump_addr), .instr(instr), .instr_valid(instr_valid), .pc(pc),
      .running(running), .done(done)
   );

   instr_fetch_unit #(
      .DATA_W(16), .ADDR_W(4), .OPCODE_W(4), .HALT_OP(4'b1111), .WRAP(1'b1)
   ) dut_w (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .start(start), .stall(stall), .jump_en(jump_en),
      .jump_addr(jump_addr), .instr(w_instr), .instr_valid(w_instr_valid), .pc(w_pc),
      .running(w_running), .done(w_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [3:0] a, input logic [15:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({instr, instr_valid, pc, running, done} !== 23'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got instr=%h v=%b pc=%0d run=%b done=%b, want all 0",
                  instr, instr_valid, pc, running, done);
      end
   endtask

   task automatic test_halt_program();
      for (int i = 0; i < 4; i++) load_word(4'(i), prog_a[i]);
      do_start();
      n_checks++;
      if (running !== 1'b1 || pc !== 4'd0 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL start_state: got run=%b pc=%0d v=%b, want run=1 pc=0 v=0", running, pc, instr_valid);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (instr !== prog_a[i] || instr_valid !== 1'b1 || pc !== 4'(i + 1)) begin
            n_fail++;
            $display("FAIL halt_prog_word%0d: got %h v=%b pc=%0d, want %h v=1 pc=%0d",
                     i, instr, instr_valid, pc, prog_a[i], i + 1);
         end
      end
      tick();
      n_checks++;
      if (instr_valid !== 1'b0 || done !== 1'b1 || running !== 1'b0 || pc !== 4'd3) begin
         n_fail++;
         $display("FAIL halt_prog_end: got v=%b done=%b run=%b pc=%0d, want v=0 done=1 run=0 pc=3",
                  instr_valid, done, running, pc);
      end
   endtask

   task automatic test_stall();
      logic [15:0] exp_seq [0:4];
      exp_seq[0] = 16'h0100; exp_seq[1] = 16'h0100; exp_seq[2] = 16'h0100;
      exp_seq[3] = 16'h4100; exp_seq[4] = 16'h5060;
      do_start();
      for (int i = 0; i < 5; i++) begin
         stall = (i == 1 || i == 2);
         tick();
         stall = 1'b0;
         n_checks++;
         if (instr !== exp_seq[i] || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_seq%0d: got %h v=%b, want %h v=1", i, instr, instr_valid, exp_seq[i]);
         end
      end
      tick();
      n_checks++;
      if (instr_valid !== 1'b0 || done !== 1'b1 || pc !== 4'd3) begin
         n_fail++;
         $display("FAIL stall_end: got v=%b done=%b pc=%0d, want v=0 done=1 pc=3", instr_valid, done, pc);
      end
   endtask

   task automatic test_load_in_fetch();
      for (int i = 0; i < 8; i++) load_word(4'(i), prog_b[i]);
      do_start();
      load_en = 1'b1; load_addr = 4'd5; load_data = 16'hAAAA;
      tick();
      load_en = 1'b0;
      for (int i = 1; i < 7; i++) begin
         tick();
         n_checks++;
         if (instr !== prog_b[i] || instr_valid !== 1'b1 || pc !== 4'(i + 1)) begin
            n_fail++;
            $display("FAIL fetch_load_word%0d: got %h v=%b pc=%0d, want %h v=1 pc=%0d",
                     i, instr, instr_valid, pc, prog_b[i], i + 1);
         end
      end
      tick();
      n_checks++;
      if (done !== 1'b1 || pc !== 4'd7 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_load_end: got done=%b pc=%0d v=%b, want done=1 pc=7 v=0", done, pc, instr_valid);
      end
   endtask

   task automatic test_jump();
      do_start();
      tick();
      tick();
      n_checks++;
      if (pc !== 4'd2 || instr !== prog_b[1]) begin
         n_fail++;
         $display("FAIL jump_pre: got pc=%0d instr=%h, want pc=2 instr=%h", pc, instr, prog_b[1]);
      end
      jump_en = 1'b1; jump_addr = 4'd6; stall = 1'b1;
      tick();
      jump_en = 1'b0; stall = 1'b0;
      n_checks++;
      if (instr_valid !== 1'b0 || pc !== 4'd6 || instr !== prog_b[1]) begin
         n_fail++;
         $display("FAIL jump_bubble: got v=%b pc=%0d instr=%h, want v=0 pc=6 instr=%h",
                  instr_valid, pc, instr, prog_b[1]);
      end
      tick();
      n_checks++;
      if (instr !== prog_b[6] || instr_valid !== 1'b1 || pc !== 4'd7) begin
         n_fail++;
         $display("FAIL jump_target: got %h v=%b pc=%0d, want %h v=1 pc=7", instr, instr_valid, pc, prog_b[6]);
      end
      tick();
      jump_en = 1'b1; jump_addr = 4'd3;
      tick();
      jump_en = 1'b0;
      n_checks++;
      if (pc !== 4'd7 || running !== 1'b0 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL jump_in_halt: got pc=%0d run=%b done=%b, want pc=7 run=0 done=1", pc, running, done);
      end
   endtask

   task automatic test_reload();
      load_en = 1'b1; load_addr = 4'd0; load_data = 16'h6123;
      start = 1'b1;
      tick();
      load_en = 1'b0; start = 1'b0;
      n_checks++;
      if (done !== 1'b0 || running !== 1'b1) begin
         n_fail++;
         $display("FAIL reload_start: got done=%b run=%b, want done=0 run=1", done, running);
      end
      tick();
      n_checks++;
      if (instr !== 16'h6123 || instr_valid !== 1'b1 || pc !== 4'd1) begin
         n_fail++;
         $display("FAIL reload_word: got %h v=%b pc=%0d, want 6123 v=1 pc=1", instr, instr_valid, pc);
      end
      for (int i = 0; i < 7; i++) tick();
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 16; i++) load_word(4'(i), 16'h2000 | 16'(i));
      do_start();
      for (int i = 0; i < 16; i++) begin
         tick();
         n_checks++;
         if (instr !== (16'h2000 | 16'(i)) || instr_valid !== 1'b1 ||
             w_instr !== (16'h2000 | 16'(i)) || w_instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_word%0d: got %h/%b wrap %h/%b, want %h valid",
                     i, instr, instr_valid, w_instr, w_instr_valid, 16'h2000 | 16'(i));
         end
      end
      n_checks++;
      if (done !== 1'b1 || running !== 1'b0 || pc !== 4'd15) begin
         n_fail++;
         $display("FAIL nowrap_end: got done=%b run=%b pc=%0d, want done=1 run=0 pc=15", done, running, pc);
      end
      n_checks++;
      if (w_done !== 1'b0 || w_running !== 1'b1 || w_pc !== 4'd0) begin
         n_fail++;
         $display("FAIL wrap_pc: got done=%b run=%b pc=%0d, want done=0 run=1 pc=0", w_done, w_running, w_pc);
      end
      tick();
      n_checks++;
      if (instr_valid !== 1'b0 || w_instr !== 16'h2000 || w_instr_valid !== 1'b1 || w_pc !== 4'd1) begin
         n_fail++;
         $display("FAIL wrap_after: got v=%b wrap %h/%b pc=%0d, want v=0 wrap 2000/1 pc=1",
                  instr_valid, w_instr, w_instr_valid, w_pc);
      end
   endtask

   task automatic test_async_reset();
      do_start();
      for (int i = 0; i < 4; i++) tick();
      n_checks++;
      if (pc !== 4'd4 || instr !== 16'h2003) begin
         n_fail++;
         $display("FAIL rst_pre: got pc=%0d instr=%h, want pc=4 instr=2003", pc, instr);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({instr, instr_valid, pc, running, done} !== 23'd0 ||
          {w_instr, w_instr_valid, w_pc, w_running, w_done} !== 23'd0) begin
         n_fail++;
         $display("FAIL rst_async: got instr=%h v=%b pc=%0d run=%b done=%b wrap instr=%h, want all 0",
                  instr, instr_valid, pc, running, done, w_instr);
      end
      tick();
      rst_n = 1'b1;
      do_start();
      tick();
      n_checks++;
      if (instr !== 16'h2000 || instr_valid !== 1'b1 || pc !== 4'd1 ||
          w_instr !== 16'h2000 || w_pc !== 4'd1) begin
         n_fail++;
         $display("FAIL rst_rerun: got %h v=%b pc=%0d wrap %h pc=%0d, want 2000 v=1 pc=1",
                  instr, instr_valid, pc, w_instr, w_pc);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      prog_a[0] = 16'h0100; prog_a[1] = 16'h4100; prog_a[2] = 16'h5060; prog_a[3] = 16'hF000;
      prog_b[0] = 16'h0001; prog_b[1] = 16'h0002; prog_b[2] = 16'h0003; prog_b[3] = 16'h0004;
      prog_b[4] = 16'h0005; prog_b[5] = 16'h6055; prog_b[6] = 16'h4066; prog_b[7] = 16'hF000;
      rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      start = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_addr = '0;
      tick();
      tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_halt_program();
      test_stall();
      test_load_in_fetch();
      test_jump();
      test_reload();
      test_wrap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
